// File: rtl/issue_pkg.sv
// rtl/issue_pkg.sv - shared widths and entry record for the issue queue
//
// Purpose: widths for ROB tags and operand data, and the per-slot entry
// record used by issue_queue and issue_queue_entry.
// Ports: none (package).
package issue_pkg;

    localparam int ROB_W         = 4;
    localparam int DATA_W        = 32;
    // The payload field is sized for the widest supported payload; narrower
    // instances zero-extend on the way in and slice on the way out.
    localparam int PAYLOAD_MAX_W = 128;

    typedef struct packed {
        logic                     valid;
        logic [ROB_W-1:0]         src0_rob;
        logic                     src0_rdy;
        logic [DATA_W-1:0]        src0_value;
        logic [ROB_W-1:0]         src1_rob;
        logic                     src1_rdy;
        logic [DATA_W-1:0]        src1_value;
        logic [ROB_W-1:0]         dst_rob;
        logic [PAYLOAD_MAX_W-1:0] payload;
    } iq_entry_t;

endpackage

// File: rtl/issue_queue_entry.sv
// rtl/issue_queue_entry.sv - one issue queue slot with wakeup and shift-in
//
// Purpose: holds one entry. Each cycle the slot either keeps its contents,
// takes the entry from the next-younger slot (shift), or takes a freshly
// decoded entry (load). The writeback wakeup is applied to whichever of
// these becomes the next value, so a shifted or newly loaded entry is
// woken in the same cycle. Flush drops the valid bit.
// Ports:
//   clk, resetn          clock, asynchronous active-low reset
//   flush                invalidate this slot
//   shift_en/shift_entry take contents of the next-younger slot
//   load_en/load_entry   take a newly inserted entry (wins over shift)
//   wb_*                 registered writeback bus
//   entry                current slot contents
module issue_queue_entry
    import issue_pkg::*;
(
    input  logic              clk,
    input  logic              resetn,
    input  logic              flush,
    input  logic              shift_en,
    input  iq_entry_t         shift_entry,
    input  logic              load_en,
    input  iq_entry_t         load_entry,
    input  logic              wb_en,
    input  logic              wb_lsmiss,
    input  logic [ROB_W-1:0]  wb_dst_rob,
    input  logic [DATA_W-1:0] wb_value,
    output iq_entry_t         entry
);

    iq_entry_t base;
    iq_entry_t nxt;
    logic      wb_live;

    // A miss writeback carries no data and must never wake a source.
    assign wb_live = wb_en && !wb_lsmiss;

    always_comb begin
        base = entry;
        if (load_en) begin
            base = load_entry;
        end else if (shift_en) begin
            base = shift_entry;
        end

        nxt = base;
        if (wb_live && base.valid) begin
            if (!base.src0_rdy && base.src0_rob == wb_dst_rob) begin
                nxt.src0_rdy   = 1'b1;
                nxt.src0_value = wb_value;
            end
            if (!base.src1_rdy && base.src1_rob == wb_dst_rob) begin
                nxt.src1_rdy   = 1'b1;
                nxt.src1_value = wb_value;
            end
        end
        if (flush) begin
            nxt.valid = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            entry <= '0;
        end else begin
            entry <= nxt;
        end
    end

endmodule

// File: rtl/issue_queue.sv
// rtl/issue_queue.sv - in-order-age issue queue with oldest-ready select
//
// Purpose: compacting age-ordered array of DEPTH slots (slot 0 oldest).
// Accepts one instruction per cycle, wakes sources from the writeback bus,
// presents the oldest entry with both sources ready to execute, and
// removes it on handshake by shifting younger slots down. snoop_hit or
// bco_valid flush everything and drop that cycle's insert.
// Ports:
//   clk, resetn                 clock, asynchronous active-low reset
//   snoop_hit, bco_valid        flush requests
//   i_wb_*                      registered writeback bus
//   i_valid, i_src*, i_dst_rob, i_payload, o_in_ready   insert side
//   o_issue_valid, i_issue_ready, o_src*_value, o_dst_rob, o_payload  issue side
//   o_count                     occupied entries
module issue_queue
    import issue_pkg::*;
#(
    parameter int DEPTH     = 4,
    parameter int PAYLOAD_W = 128
) (
    input  logic                       clk,
    input  logic                       resetn,
    input  logic                       snoop_hit,
    input  logic                       bco_valid,
    input  logic                       i_wb_en,
    input  logic [ROB_W-1:0]           i_wb_dst_rob,
    input  logic [DATA_W-1:0]          i_wb_value,
    input  logic                       i_wb_lsmiss,
    input  logic                       i_valid,
    input  logic [ROB_W-1:0]           i_src0_rob,
    input  logic [ROB_W-1:0]           i_src1_rob,
    input  logic                       i_src0_rdy,
    input  logic                       i_src1_rdy,
    input  logic [DATA_W-1:0]          i_src0_value,
    input  logic [DATA_W-1:0]          i_src1_value,
    input  logic [ROB_W-1:0]           i_dst_rob,
    input  logic [PAYLOAD_W-1:0]       i_payload,
    output logic                       o_in_ready,
    output logic                       o_issue_valid,
    input  logic                       i_issue_ready,
    output logic [DATA_W-1:0]          o_src0_value,
    output logic [DATA_W-1:0]          o_src1_value,
    output logic [ROB_W-1:0]           o_dst_rob,
    output logic [PAYLOAD_W-1:0]       o_payload,
    output logic [$clog2(DEPTH+1)-1:0] o_count
);

    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int IDX_W = $clog2(DEPTH);

    iq_entry_t        slot_q    [DEPTH];
    iq_entry_t        shift_src [DEPTH];
    iq_entry_t        new_entry;
    iq_entry_t        sel_entry;
    logic [DEPTH-1:0] shift_en;
    logic [DEPTH-1:0] load_en;
    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] ins_slot;
    logic [IDX_W-1:0] sel_idx;
    logic             sel_found;
    logic             flush;
    logic             issue_fire;
    logic             ins_fire;

    assign flush      = snoop_hit | bco_valid;
    // Depends on registered count only, so a same-cycle issue never frees
    // a slot for a same-cycle insert into a full queue.
    assign o_in_ready = (count_q < CNT_W'(DEPTH));
    assign ins_fire   = i_valid && o_in_ready && !flush;
    assign issue_fire = sel_found && i_issue_ready;
    // When an issue frees a slot in the same cycle, the tail moves down by one.
    assign ins_slot   = issue_fire ? (count_q - CNT_W'(1)) : count_q;

    always_comb begin
        new_entry                          = '0;
        new_entry.valid                    = 1'b1;
        new_entry.src0_rob                 = i_src0_rob;
        new_entry.src0_rdy                 = i_src0_rdy;
        new_entry.src0_value               = i_src0_value;
        new_entry.src1_rob                 = i_src1_rob;
        new_entry.src1_rdy                 = i_src1_rdy;
        new_entry.src1_value               = i_src1_value;
        new_entry.dst_rob                  = i_dst_rob;
        new_entry.payload[PAYLOAD_W-1:0]   = i_payload;
    end

    // Oldest-ready select: scan youngest to oldest so the last hit wins.
    always_comb begin
        sel_found = 1'b0;
        sel_idx   = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (slot_q[i].valid && slot_q[i].src0_rdy && slot_q[i].src1_rdy) begin
                sel_found = 1'b1;
                sel_idx   = IDX_W'(i);
            end
        end
    end

    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            shift_en[i] = issue_fire && (IDX_W'(i) >= sel_idx);
            load_en[i]  = ins_fire && (CNT_W'(i) == ins_slot);
        end
    end

    for (genvar g = 0; g < DEPTH; g++) begin : g_slot
        if (g == DEPTH - 1) begin : g_tail
            assign shift_src[g] = '0;
        end else begin : g_body
            assign shift_src[g] = slot_q[g+1];
        end

        issue_queue_entry u_entry (
            .clk         (clk),
            .resetn      (resetn),
            .flush       (flush),
            .shift_en    (shift_en[g]),
            .shift_entry (shift_src[g]),
            .load_en     (load_en[g]),
            .load_entry  (new_entry),
            .wb_en       (i_wb_en),
            .wb_lsmiss   (i_wb_lsmiss),
            .wb_dst_rob  (i_wb_dst_rob),
            .wb_value    (i_wb_value),
            .entry       (slot_q[g])
        );
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            count_q <= '0;
        end else if (flush) begin
            count_q <= '0;
        end else begin
            count_q <= count_q + CNT_W'(ins_fire) - CNT_W'(issue_fire);
        end
    end

    // Data outputs read zero whenever nothing is presented.
    assign sel_entry     = sel_found ? slot_q[sel_idx] : '0;
    assign o_issue_valid = sel_found;
    assign o_src0_value  = sel_entry.src0_value;
    assign o_src1_value  = sel_entry.src1_value;
    assign o_dst_rob     = sel_entry.dst_rob;
    assign o_payload     = sel_entry.payload[PAYLOAD_W-1:0];
    assign o_count       = count_q;

endmodule

// File: tb/tb_issue_queue.sv
// tb/tb_issue_queue.sv - self-checking bench for issue_queue
module tb_issue_queue;

    localparam int DEPTH     = 4;
    localparam int PAYLOAD_W = 128;
    localparam int CNT_W     = $clog2(DEPTH + 1);

    logic                 clk = 1'b0;
    logic                 resetn;
    logic                 snoop_hit, bco_valid;
    logic                 i_wb_en, i_wb_lsmiss;
    logic [3:0]           i_wb_dst_rob;
    logic [31:0]          i_wb_value;
    logic                 i_valid;
    logic [3:0]           i_src0_rob, i_src1_rob, i_dst_rob;
    logic                 i_src0_rdy, i_src1_rdy;
    logic [31:0]          i_src0_value, i_src1_value;
    logic [PAYLOAD_W-1:0] i_payload;
    logic                 o_in_ready, o_issue_valid, i_issue_ready;
    logic [31:0]          o_src0_value, o_src1_value;
    logic [3:0]           o_dst_rob;
    logic [PAYLOAD_W-1:0] o_payload;
    logic [CNT_W-1:0]     o_count;

    issue_queue #(.DEPTH(DEPTH), .PAYLOAD_W(PAYLOAD_W)) dut (
        .clk(clk), .resetn(resetn), .snoop_hit(snoop_hit), .bco_valid(bco_valid),
        .i_wb_en(i_wb_en), .i_wb_dst_rob(i_wb_dst_rob), .i_wb_value(i_wb_value),
        .i_wb_lsmiss(i_wb_lsmiss), .i_valid(i_valid),
        .i_src0_rob(i_src0_rob), .i_src1_rob(i_src1_rob),
        .i_src0_rdy(i_src0_rdy), .i_src1_rdy(i_src1_rdy),
        .i_src0_value(i_src0_value), .i_src1_value(i_src1_value),
        .i_dst_rob(i_dst_rob), .i_payload(i_payload), .o_in_ready(o_in_ready),
        .o_issue_valid(o_issue_valid), .i_issue_ready(i_issue_ready),
        .o_src0_value(o_src0_value), .o_src1_value(o_src1_value),
        .o_dst_rob(o_dst_rob), .o_payload(o_payload), .o_count(o_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]           s0_rob, s1_rob, dst;
        logic                 s0_rdy, s1_rdy;
        logic [31:0]          s0_val, s1_val;
        logic [PAYLOAD_W-1:0] pl;
    } m_ent_t;

    m_ent_t mq[$];
    int     n_cmp  = 0;
    int     n_err  = 0;
    int     n_viol = 0;

    // Upstream protocol monitor: i_valid while the queue is full.
    always @(posedge clk) begin
        if (resetn && i_valid && !o_in_ready) begin
            n_viol++;
            $display("note: i_valid while queue full at %0t", $time);
        end
    end

    task automatic chk(input string tag, input logic [PAYLOAD_W-1:0] obs,
                       input logic [PAYLOAD_W-1:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int model_sel();
        for (int k = 0; k < mq.size(); k++)
            if (mq[k].s0_rdy && mq[k].s1_rdy) return k;
        return -1;
    endfunction

    function automatic m_ent_t woken(m_ent_t e);
        if (i_wb_en && !i_wb_lsmiss) begin
            if (!e.s0_rdy && e.s0_rob == i_wb_dst_rob) begin e.s0_rdy = 1'b1; e.s0_val = i_wb_value; end
            if (!e.s1_rdy && e.s1_rob == i_wb_dst_rob) begin e.s1_rdy = 1'b1; e.s1_val = i_wb_value; end
        end
        return e;
    endfunction

    task automatic model_step(input int sel);
        m_ent_t e;
        bit     room;
        room = mq.size() < DEPTH;
        if (snoop_hit || bco_valid) begin
            mq.delete();
        end else begin
            if (sel >= 0 && i_issue_ready) mq.delete(sel);
            foreach (mq[k]) mq[k] = woken(mq[k]);
            if (i_valid && room) begin
                e.s0_rob = i_src0_rob; e.s0_rdy = i_src0_rdy; e.s0_val = i_src0_value;
                e.s1_rob = i_src1_rob; e.s1_rdy = i_src1_rdy; e.s1_val = i_src1_value;
                e.dst    = i_dst_rob;  e.pl     = i_payload;
                mq.push_back(woken(e));
            end
        end
    endtask

    // Called in the low clock phase with inputs already driven.
    task automatic cycle();
        int sel;
        sel = model_sel();
        chk("issue_valid", o_issue_valid, sel >= 0);
        chk("in_ready", o_in_ready, mq.size() < DEPTH);
        chk("count", o_count, mq.size());
        if (sel >= 0) begin
            chk("src0", o_src0_value, mq[sel].s0_val);
            chk("src1", o_src1_value, mq[sel].s1_val);
            chk("dst", o_dst_rob, mq[sel].dst);
            chk("payload", o_payload, mq[sel].pl);
        end
        @(posedge clk);
        model_step(sel);
        @(negedge clk);
    endtask

    task automatic set_in(input logic [3:0] r0, input logic y0, input logic [31:0] v0,
                          input logic [3:0] r1, input logic y1, input logic [31:0] v1,
                          input logic [3:0] d);
        i_valid    = 1'b1;
        i_src0_rob = r0; i_src0_rdy = y0; i_src0_value = v0;
        i_src1_rob = r1; i_src1_rdy = y1; i_src1_value = v1;
        i_dst_rob  = d;
        i_payload  = {$urandom, $urandom, $urandom, $urandom};
    endtask

    task automatic set_wb(input logic [3:0] rob, input logic [31:0] val, input logic miss);
        i_wb_en = 1'b1; i_wb_dst_rob = rob; i_wb_value = val; i_wb_lsmiss = miss;
    endtask

    task automatic idle();
        i_valid = 1'b0; i_wb_en = 1'b0; i_wb_lsmiss = 1'b0;
        snoop_hit = 1'b0; bco_valid = 1'b0;
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_iv"}, o_issue_valid, 1'b0);
        chk({tag, "_inr"}, o_in_ready, 1'b1);
        chk({tag, "_cnt"}, o_count, 0);
        chk({tag, "_s0"}, o_src0_value, 0);
        chk({tag, "_s1"}, o_src1_value, 0);
        chk({tag, "_dst"}, o_dst_rob, 0);
        chk({tag, "_pl"}, o_payload, 0);
    endtask

    initial begin
        resetn = 1'b0; idle(); i_issue_ready = 1'b0;
        i_wb_dst_rob = '0; i_wb_value = '0;
        set_in(0, 0, 0, 0, 0, 0, 0); i_valid = 1'b0;
        repeat (3) @(negedge clk);
        chk_reset_outputs("reset");
        resetn = 1'b1;
        @(negedge clk);

        // Basic issue
        i_issue_ready = 1'b1;
        set_in(0, 1, 32'h11, 0, 1, 32'h22, 3);
        cycle(); idle();
        chk("basic_valid", o_issue_valid, 1'b1);
        chk("basic_src0", o_src0_value, 32'h11);
        chk("basic_src1", o_src1_value, 32'h22);
        chk("basic_dst", o_dst_rob, 3);
        cycle();
        chk("basic_count", o_count, 0);

        // Wakeup from writeback
        set_in(0, 1, 32'h1, 5, 0, 0, 4);
        cycle(); idle();
        chk("wk_wait", o_issue_valid, 1'b0);
        set_wb(5, 32'hABCD, 1'b0);
        cycle(); idle();
        chk("wk_valid", o_issue_valid, 1'b1);
        chk("wk_src1", o_src1_value, 32'hABCD);
        cycle();

        // Miss writeback never wakes
        set_in(0, 1, 32'h1, 5, 0, 0, 4);
        cycle(); idle();
        set_wb(5, 32'hABCD, 1'b1);
        cycle(); idle();
        chk("miss_noissue", o_issue_valid, 1'b0);
        cycle();
        chk("miss_still", o_issue_valid, 1'b0);
        bco_valid = 1'b1; cycle(); idle();

        // Insert bypass
        set_in(7, 0, 0, 0, 1, 32'h9, 6);
        set_wb(7, 32'h55, 1'b0);
        cycle(); idle();
        chk("byp_valid", o_issue_valid, 1'b1);
        chk("byp_src0", o_src0_value, 32'h55);
        cycle();
        chk("byp_count", o_count, 0);

        // Fill, overflow attempt, age-ordered issue
        i_issue_ready = 1'b0;
        for (int k = 0; k < DEPTH; k++) begin
            set_in(4'(8 + k), 0, 0, 0, 1, 32'(k), 4'(k));
            cycle();
        end
        idle();
        chk("fill_in_ready", o_in_ready, 1'b0);
        set_in(0, 1, 1, 0, 1, 1, 15);
        cycle(); idle();
        chk("fill_viol", n_viol, 1);
        chk("fill_count", o_count, DEPTH);
        set_wb(10, 32'h200, 1'b0); cycle(); idle();
        chk("age_first2", o_dst_rob, 2);
        set_wb(8, 32'h100, 1'b0); cycle(); idle();
        chk("age_oldest", o_dst_rob, 0);
        i_issue_ready = 1'b1;
        cycle();
        chk("age_next", o_dst_rob, 2);
        cycle();
        chk("age_count", o_count, DEPTH - 2);
        bco_valid = 1'b1; cycle(); idle();

        // Flush with concurrent insert and issue
        for (int f = 0; f < 2; f++) begin
            i_issue_ready = 1'b0;
            for (int k = 0; k < 3; k++) begin
                set_in(0, 1, 32'(k), 0, 1, 32'(k), 4'(k)); cycle();
            end
            set_in(0, 1, 32'h77, 0, 1, 32'h78, 9);
            i_issue_ready = 1'b1;
            if (f == 0) bco_valid = 1'b1; else snoop_hit = 1'b1;
            cycle(); idle();
            chk("flush_count", o_count, 0);
            chk("flush_iv", o_issue_valid, 1'b0);
        end

        // Asynchronous reset mid-cycle
        i_issue_ready = 1'b0;
        set_in(0, 1, 32'h3, 0, 1, 32'h4, 1); cycle();
        set_in(2, 0, 0, 0, 1, 32'h4, 2); cycle(); idle();
        #2 resetn = 1'b0;
        #1 chk_reset_outputs("async");
        mq.delete();
        #1 resetn = 1'b1;
        @(negedge clk);

        // Randomized traffic against the reference model
        for (int n = 0; n < 3000; n++) begin
            i_valid      = (mq.size() < DEPTH) && ($urandom_range(9) < 6);
            i_src0_rob   = 4'($urandom_range(7));
            i_src1_rob   = 4'($urandom_range(7));
            i_src0_rdy   = 1'($urandom_range(1));
            i_src1_rdy   = 1'($urandom_range(1));
            i_src0_value = $urandom;
            i_src1_value = $urandom;
            i_dst_rob    = 4'($urandom_range(15));
            i_payload    = {$urandom, $urandom, $urandom, $urandom};
            i_wb_en      = 1'($urandom_range(1));
            i_wb_dst_rob = 4'($urandom_range(7));
            i_wb_value   = $urandom;
            i_wb_lsmiss  = ($urandom_range(4) == 0);
            i_issue_ready = ($urandom_range(9) < 7);
            bco_valid    = ($urandom_range(49) == 0);
            snoop_hit    = ($urandom_range(49) == 0);
            cycle();
        end
        idle();
        chk("final_viol", n_viol, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/issue_queue.md
# issue_queue

In-order-age issue queue that sits directly downstream of the decode/issue pipeline registers. It accepts one decoded instruction per cycle together with its source-operand tags, readiness and values, and holds it until both operands are ready. Operand readiness is updated from the registered writeback bus. Each cycle it selects the oldest fully-ready entry and presents it to the execute stage over a valid/ready handshake; branch-commit override and snoop hit flush all held entries.

## Interface
Parameters:
- DEPTH, 4: number of entries; 2..8.
- PAYLOAD_W, 128: width of the opaque payload (pc, imm, fid, branch/load/store flags, pipe selects, cmds), carried uninterpreted.

Ports:
- clk  in  1  clock; single clock domain.
- resetn  in  1  reset; asynchronous, active-low.
- snoop_hit  in  1  flush request.
- bco_valid  in  1  branch-commit-override flush request.
- i_wb_en  in  1  writeback valid (registered writeback bus).
- i_wb_dst_rob  in  4  writeback ROB tag.
- i_wb_value  in  32  writeback data.
- i_wb_lsmiss  in  1  load/store miss; this writeback carries no valid data.
- i_valid  in  1  incoming instruction valid.
- i_src0_rob / i_src1_rob  in  4  source ROB tags.
- i_src0_rdy / i_src1_rdy  in  1  source already available.
- i_src0_value / i_src1_value  in  32  source values, meaningful when rdy.
- i_dst_rob  in  4  destination ROB tag.
- i_payload  in  PAYLOAD_W  opaque instruction fields.
- o_in_ready  out  1  queue can accept this cycle.
- o_issue_valid  out  1  an issuable entry is presented.
- i_issue_ready  in  1  execute stage accepts.
- o_src0_value / o_src1_value  out  32  operands of the presented entry.
- o_dst_rob  out  4  destination tag of the presented entry.
- o_payload  out  PAYLOAD_W  payload of the presented entry.
- o_count  out  $clog2(DEPTH+1)  number of occupied entries.

## Operation
- **Storage.** Entries are a compacting array kept in age order. Slot 0 is the oldest; slots 0..count-1 are valid.
- **Insert.**
  - Condition: i_valid && o_in_ready && !flush.
  - The new entry is written to slot count, or to slot count-1 if an issue fires in the same cycle.
- **Insert bypass.** If an incoming source is not rdy and a non-miss writeback matches its tag in the same cycle, the source is stored as rdy with i_wb_value.
- **Wakeup.**
  - Condition, per valid entry and source: i_wb_en && !i_wb_lsmiss && !srcN_rdy && srcN_rob == i_wb_dst_rob.
  - Effect: set srcN_rdy and capture i_wb_value.
  - A writeback with lsmiss=1 never wakes anything.
- **Select.** The presented entry is the lowest-index valid entry with both sources rdy, evaluated on stored state. o_issue_valid = (that entry exists).
- **Issue.**
  - Fires on o_issue_valid && i_issue_ready.
  - The selected slot is removed and all younger slots shift down by one.
  - Wakeup applies to the shifted entries in the same cycle.
- **Flush.**
  - flush = snoop_hit || bco_valid.
  - Clears all valid bits and sets count to 0.
  - Drops that cycle's insert.
  - Has priority over insert, issue and wakeup.
- o_in_ready = (count < DEPTH). It has no combinational path from i_issue_ready.
- i_valid while !o_in_ready is ignored and the input is lost; upstream must not do this, and a bench assertion flags it.

## Timing
- **Reset values.** During reset and after release:
  - count = 0, all entries invalid, all storage zero.
  - o_issue_valid = 0, o_in_ready = 1, o_count = 0.
  - o_src0_value / o_src1_value / o_dst_rob / o_payload = 0.
- **Minimum latency.** Instruction inserted with both sources rdy at edge N → o_issue_valid high in cycle N+1.
- **Wakeup to issue.** Wakeup at edge N → entry eligible in cycle N+1. A wakeup never makes an entry issuable in the same cycle.
- o_issue_valid and the data outputs are combinational from registered state only.
- Once presented, an entry stays presented until accepted, unless an older entry becomes ready (oldest-first may switch the selection) or a flush occurs. The execute stage must sample only on handshake.
- **Full with issue.** count=DEPTH and an issue fires → o_in_ready is still 0 that cycle; it becomes 1 in the next cycle.
- **Reset mid-operation.** Asserting resetn low clears state immediately (asynchronous). Pending entries are lost.

## Structure
- Shared package issue_pkg holds:
  - ROB_W = 4 and DATA_W = 32.
  - The entry struct: valid, src0/1 rob/rdy/value, dst_rob, payload.
- One sub-module, issue_queue_entry: holds one slot's wakeup compare and rdy/value update, with a shift-in port from the next slot. The top level holds the count, the oldest-ready priority select, the shift control and the flush.

## Test plan
- **Basic issue.** Reset, then insert {src0 rdy=1 val=0x11, src1 rdy=1 val=0x22, dst=3}, with i_issue_ready=1 → o_issue_valid=1 the next cycle with values 0x11/0x22 and dst 3; count returns to 0.
- **Wakeup vs. lsmiss.**
  - Insert with src1 not rdy, tag 5; then i_wb_en=1, tag 5, value 0xABCD → issue the following cycle with src1=0xABCD.
  - The same sequence with lsmiss=1 → no issue.
- **Insert bypass.** Insert with src0 not rdy, tag 7, in the same cycle as a writeback to tag 7 with value 0x55 → issued the next cycle with src0=0x55.
- **Fill and age order.**
  - Fill DEPTH entries with i_issue_ready=0 → o_in_ready=0; extra i_valid is ignored and the assertion fires.
  - Make entry 2 then entry 0 ready → entry 0 issues first, then entry 2, and younger entries compact.
- **Flush.** With 3 entries held, assert bco_valid together with i_valid and i_issue_ready → next cycle count=0 and o_issue_valid=0; the input is dropped. Repeat with snoop_hit.
- **Async reset.** Assert resetn low mid-cycle with entries held → outputs go to reset values before the next clock edge.
